// File: rtl/debounce_filter.sv
// Per-bit debounce filter with optional one-cycle rise/fall strobes.
// Define DEBOUNCE_FILTER_EDGE_EN to build the strobe registers; otherwise rise/fall are tied low.
module debounce_filter_lane #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter bit          INIT_BIT        = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic out,
    output logic rise,
    output logic fall
);
    localparam int unsigned CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt;
    logic          differ;
    logic          done;

    assign differ = (in != out);
    assign done   = differ && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            out <= INIT_BIT;
            cnt <= '0;
        end else if (done) begin
            out <= in;
            cnt <= '0;
        end else if (differ) begin
            cnt <= cnt + 1'b1;
        end else begin
            cnt <= '0;
        end
    end

`ifdef DEBOUNCE_FILTER_EDGE_EN
    // Strobes share the edge that updates out, so they are high exactly for its first new cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= done && in;
            fall <= done && !in;
        end
    end
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif
endmodule

module debounce_filter #(
    parameter int unsigned       WIDTH           = 1,
    parameter int unsigned       DEBOUNCE_CYCLES = 4,
    parameter logic [WIDTH-1:0]  INIT            = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);
    generate
        if (DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
            $error("debounce_filter: DEBOUNCE_CYCLES must be >= 1");
        end
    endgenerate

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_lane
            debounce_filter_lane #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .INIT_BIT        (INIT[i])
            ) u_lane (
                .clk  (clk),
                .rst  (rst),
                .in   (in[i]),
                .out  (out[i]),
                .rise (rise[i]),
                .fall (fall[i])
            );
        end
    endgenerate
endmodule

// File: tb/tb_debounce_filter.sv
// Directed bench for debounce_filter: WIDTH=4, DEBOUNCE_CYCLES=4, INIT=4'b1010.
// Strobe expectations follow DEBOUNCE_FILTER_EDGE_EN; with it undefined they must stay 0.
module tb_debounce_filter;
    localparam int unsigned W    = 4;
    localparam logic [W-1:0] INIT = 4'b1010;
`ifdef DEBOUNCE_FILTER_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic [W-1:0] din;
    logic [W-1:0] dout;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    int           passed;
    int           total;

    debounce_filter #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (4),
        .INIT            (INIT)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .in   (din),
        .out  (dout),
        .rise (rise),
        .fall (fall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive v at a falling edge, let one rising edge sample it, return at the next falling edge.
    task automatic cyc(input logic [W-1:0] v);
        din = v;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(INIT);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [W-1:0] exp_r;
        logic [W-1:0] exp_f;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            cyc(W'($urandom));
            total++;
            if (dout !== INIT || rise !== '0 || fall !== '0)
                $display("FAIL reset_hold%0d: out=%b rise=%b fall=%b want out=%b rise=0 fall=0", k, dout, rise, fall, INIT);
            else passed++;
        end
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc(4'b0101);
            total++;
            if (dout !== INIT || rise !== '0 || fall !== '0)
                $display("FAIL reset_after%0d: out=%b rise=%b fall=%b want out=%b rise=0 fall=0", k, dout, rise, fall, INIT);
            else passed++;
        end
        cyc(4'b0101);
        exp_r = EDGE ? 4'b0101 : 4'b0000;
        exp_f = EDGE ? 4'b1010 : 4'b0000;
        total++;
        if (dout !== 4'b0101 || rise !== exp_r || fall !== exp_f)
            $display("FAIL reset_first_change: out=%b rise=%b fall=%b want out=0101 rise=%b fall=%b", dout, rise, fall, exp_r, exp_f);
        else passed++;
    endtask

    task automatic test_clean_change();
        logic [W-1:0] exp_r;
        exp_r = EDGE ? 4'b0001 : 4'b0000;
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            cyc(4'b1011);
            total++;
            if (dout !== INIT || rise !== '0 || fall !== '0)
                $display("FAIL clean_E%0d: out=%b rise=%b fall=%b want out=%b no strobe", k, dout, rise, fall, INIT);
            else passed++;
        end
        cyc(4'b1011);
        total++;
        if (dout !== 4'b1011 || rise !== exp_r || fall !== '0)
            $display("FAIL clean_E4: out=%b rise=%b fall=%b want out=1011 rise=%b fall=0", dout, rise, fall, exp_r);
        else passed++;
        cyc(4'b1011);
        total++;
        if (dout !== 4'b1011 || rise !== '0 || fall !== '0)
            $display("FAIL clean_E5: out=%b rise=%b fall=%b want out=1011 no strobe", dout, rise, fall);
        else passed++;
    endtask

    task automatic test_glitch();
        logic [W-1:0] pat [7];
        logic [W-1:0] exp_r;
        pat = '{4'b1011, 4'b1011, 4'b1011, 4'b1010, 4'b1011, 4'b1011, 4'b1011};
        exp_r = EDGE ? 4'b0001 : 4'b0000;
        do_reset();
        for (int k = 0; k < 7; k++) begin
            cyc(pat[k]);
            total++;
            if (dout !== INIT || rise !== '0 || fall !== '0)
                $display("FAIL glitch_step%0d: out=%b rise=%b fall=%b want out=%b no strobe", k, dout, rise, fall, INIT);
            else passed++;
        end
        cyc(4'b1011);
        total++;
        if (dout !== 4'b1011 || rise !== exp_r)
            $display("FAIL glitch_final: out=%b rise=%b want out=1011 rise=%b", dout, rise, exp_r);
        else passed++;
    endtask

    task automatic test_independent();
        logic [W-1:0] pat  [7];
        logic [W-1:0] eo   [7];
        logic [W-1:0] er   [7];
        logic [W-1:0] ef   [7];
        pat = '{4'b1011, 4'b1011, 4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b1001};
        eo  = '{4'b1010, 4'b1010, 4'b1010, 4'b1011, 4'b1011, 4'b1001, 4'b1001};
        er  = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        ef  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000};
        do_reset();
        for (int k = 0; k < 7; k++) begin
            cyc(pat[k]);
            total++;
            if (dout !== eo[k] || rise !== (EDGE ? er[k] : 4'b0000) || fall !== (EDGE ? ef[k] : 4'b0000))
                $display("FAIL indep_E%0d: out=%b rise=%b fall=%b want out=%b rise=%b fall=%b",
                         k + 1, dout, rise, fall, eo[k], EDGE ? er[k] : 4'b0000, EDGE ? ef[k] : 4'b0000);
            else passed++;
        end
    endtask

    task automatic test_reset_mid_count();
        logic [W-1:0] exp_r;
        exp_r = EDGE ? 4'b0001 : 4'b0000;
        do_reset();
        for (int k = 0; k < 3; k++) cyc(4'b1011);
        rst = 1'b1;
        cyc(4'b1011);
        rst = 1'b0;
        total++;
        if (dout !== INIT || rise !== '0 || fall !== '0)
            $display("FAIL midrst_edge: out=%b rise=%b fall=%b want out=%b no strobe", dout, rise, fall, INIT);
        else passed++;
        for (int k = 1; k <= 3; k++) begin
            cyc(4'b1011);
            total++;
            if (dout !== INIT || rise !== '0)
                $display("FAIL midrst_fresh%0d: out=%b rise=%b want out=%b rise=0", k, dout, rise, INIT);
            else passed++;
        end
        cyc(4'b1011);
        total++;
        if (dout !== 4'b1011 || rise !== exp_r)
            $display("FAIL midrst_done: out=%b rise=%b want out=1011 rise=%b", dout, rise, exp_r);
        else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst    = 1'b1;
        din    = '0;
        test_reset();
        test_clean_change();
        test_glitch();
        test_independent();
        test_reset_mid_count();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
